// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory stream arbiter.
package mem_arb_pkg;

    localparam int unsigned GrantCntW = 16;

    typedef enum logic {
        ARB_FREE,
        ARB_LOCKED
    } arb_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Round-robin priority scan: first valid requester at or after i_ptr, wrapping.
module mem_arb_rr
    import mem_arb_pkg::*;
#(
    parameter int unsigned NumReq = 4
) (
    input  logic [NumReq-1:0]         i_valid,
    input  logic [$clog2(NumReq)-1:0] i_ptr,
    output logic [$clog2(NumReq)-1:0] o_idx,
    output logic                      o_any
);

    localparam int unsigned IdxW = $clog2(NumReq);

    always_comb begin
        int unsigned w_cand;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = 32'(i_ptr);
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (!o_any && i_valid[IdxW'(w_cand)]) begin
                o_any = 1'b1;
                o_idx = IdxW'(w_cand);
            end
            w_cand = wrap_inc(w_cand, NumReq);
        end
    end

endmodule

// File: rtl/stream_fifo.sv
// In-order storage queue with registered head (non-fall-through).
// The caller tracks occupancy; a push and a pop may coincide even when full.
module stream_fifo
    import mem_arb_pkg::*;
#(
    parameter type         T     = logic,
    parameter int unsigned Depth = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    T                r_mem [Depth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= PtrW'(wrap_inc(32'(r_wr_ptr), Depth));
            end
            if (i_pop) begin
                r_rd_ptr <= PtrW'(wrap_inc(32'(r_rd_ptr), Depth));
            end
        end
    end

    assign o_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/mem_stream_arbiter.sv
// Round-robin arbiter sharing one memory request/response stream among NumReq requesters.
// Define MEM_ARB_GRANT_CNT_EN to build per-requester 16-bit grant counters.
module mem_stream_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned MaxOutstanding = 2,
    parameter type         mem_req_t      = logic,
    parameter type         mem_resp_t     = logic
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  mem_req_t [NumReq-1:0]            req_i,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    output mem_resp_t                        resp_o,
    output logic [NumReq-1:0]                resp_valid_o,
    input  logic [NumReq-1:0]                resp_ready_i,
    output mem_req_t                         mem_req_o,
    output logic                             mem_req_valid_o,
    input  logic                             mem_req_ready_i,
    input  mem_resp_t                        mem_resp_i,
    input  logic                             mem_resp_valid_i,
    output logic                             mem_resp_ready_o,
    output logic [NumReq-1:0][GrantCntW-1:0] grant_cnt_o
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    arb_state_e      r_state;
    arb_state_e      w_state_next;
    logic [IdxW-1:0] r_rr_ptr;
    logic [IdxW-1:0] r_lock_idx;
    logic [IdxW-1:0] w_lock_idx_next;
    logic [IdxW-1:0] w_rr_idx;
    logic [IdxW-1:0] w_grant;
    logic [IdxW-1:0] w_head;
    logic [CntW-1:0] r_cnt;
    logic            w_any_valid;
    logic            w_grant_valid;
    logic            w_can_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_q_empty;

    mem_arb_rr #(
        .NumReq(NumReq)
    ) u_rr (
        .i_valid(req_valid_i),
        .i_ptr  (r_rr_ptr),
        .o_idx  (w_rr_idx),
        .o_any  (w_any_valid)
    );

    stream_fifo #(
        .T    (logic [IdxW-1:0]),
        .Depth(MaxOutstanding)
    ) u_id_q (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_push(w_push),
        .i_data(w_grant),
        .i_pop (w_pop),
        .o_data(w_head)
    );

    assign w_q_empty   = (r_cnt == '0);
    assign w_pop       = !w_q_empty && mem_resp_valid_i && resp_ready_i[w_head];
    // A pop in the same cycle frees the slot the new request takes.
    assign w_can_issue = (r_cnt < CntW'(MaxOutstanding)) || w_pop;
    assign w_push      = mem_req_valid_o && mem_req_ready_i;

    always_comb begin
        w_grant       = w_rr_idx;
        w_grant_valid = w_any_valid;
        if (r_state == ARB_LOCKED) begin
            w_grant       = r_lock_idx;
            w_grant_valid = req_valid_i[r_lock_idx];
        end
        mem_req_valid_o      = w_grant_valid && w_can_issue;
        mem_req_o            = req_i[w_grant];
        req_ready_o          = '0;
        req_ready_o[w_grant] = mem_req_ready_i && w_can_issue;
    end

    always_comb begin
        w_state_next    = r_state;
        w_lock_idx_next = r_lock_idx;
        unique case (r_state)
            ARB_FREE: begin
                if (mem_req_valid_o && !mem_req_ready_i) begin
                    w_state_next    = ARB_LOCKED;
                    w_lock_idx_next = w_grant;
                end
            end
            ARB_LOCKED: begin
                if (w_push) begin
                    w_state_next = ARB_FREE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ARB_FREE;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lock_idx <= w_lock_idx_next;
            if (w_push) begin
                r_rr_ptr <= IdxW'(wrap_inc(32'(w_grant), NumReq));
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CntW'(1);
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - CntW'(1);
            end
        end
    end

    always_comb begin
        resp_valid_o     = '0;
        mem_resp_ready_o = 1'b0;
        if (!w_q_empty) begin
            resp_valid_o[w_head] = mem_resp_valid_i;
            mem_resp_ready_o     = resp_ready_i[w_head];
        end
    end

    assign resp_o = mem_resp_i;

`ifdef MEM_ARB_GRANT_CNT_EN
    logic [NumReq-1:0][GrantCntW-1:0] r_grant_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_grant_cnt <= '0;
        end else if (w_push) begin
            r_grant_cnt[w_grant] <= r_grant_cnt[w_grant] + GrantCntW'(1);
        end
    end

    assign grant_cnt_o = r_grant_cnt;
`else
    assign grant_cnt_o = '0;
`endif

    // A response with nothing outstanding has no owner.
    a_resp_has_owner: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mem_resp_valid_i && w_q_empty));

endmodule

// File: tb/tb_mem_stream_arbiter.sv
// Randomized bench for mem_stream_arbiter against a queue-based reference model.
module tb_mem_stream_arbiter;

    localparam int unsigned NumReq = 4;
    localparam int unsigned MaxOut = 2;

    typedef logic [7:0] req_t;
    typedef logic [7:0] resp_t;

    logic                      clk = 1'b0;
    logic                      rst;
    req_t [NumReq-1:0]         req_i;
    logic [NumReq-1:0]         req_valid_i;
    logic [NumReq-1:0]         req_ready_o;
    resp_t                     resp_o;
    logic [NumReq-1:0]         resp_valid_o;
    logic [NumReq-1:0]         resp_ready_i;
    req_t                      mem_req_o;
    logic                      mem_req_valid_o;
    logic                      mem_req_ready_i;
    resp_t                     mem_resp_i;
    logic                      mem_resp_valid_i;
    logic                      mem_resp_ready_o;
    logic [NumReq-1:0][15:0]   grant_cnt_o;

    always #5 clk = ~clk;

    mem_stream_arbiter #(
        .NumReq        (NumReq),
        .MaxOutstanding(MaxOut),
        .mem_req_t     (req_t),
        .mem_resp_t    (resp_t)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_i           (req_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .resp_o          (resp_o),
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (resp_ready_i),
        .mem_req_o       (mem_req_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_resp_i      (mem_resp_i),
        .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_ready_o(mem_resp_ready_o),
        .grant_cnt_o     (grant_cnt_o)
    );

    // Reference model: owners of outstanding requests in issue order, the next
    // requester to favour, and a requester whose offer is waiting for memory.
    int          q[$];
    int          rr;
    int          lock;
    logic [15:0] gcnt [NumReq];
    logic [NumReq-1:0] pend_v;
    req_t        pend_d [NumReq];

    int n_cmp;
    int n_mis;
    int p_req;
    int p_rdy;
    int p_rv;
    int p_rr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rr   = 0;
        lock = -1;
        for (int i = 0; i < NumReq; i++) gcnt[i] = '0;
    endtask

    task automatic check_counters();
        for (int i = 0; i < NumReq; i++) begin
`ifdef MEM_ARB_GRANT_CNT_EN
            check_val("grant_cnt", 64'(grant_cnt_o[i]), 64'(gcnt[i]));
`else
            check_val("grant_cnt", 64'(grant_cnt_o[i]), 64'(0));
`endif
        end
    endtask

    // Called just after a falling edge: drive, predict, check, then commit at the rising edge.
    task automatic step_body();
        int                g;
        bit                gv;
        bit                pop;
        bit                can;
        bit                vout;
        bit                hs;
        logic [NumReq-1:0] exp_rdy;
        logic [NumReq-1:0] exp_rv;
        for (int i = 0; i < NumReq; i++) begin
            if (!pend_v[i] && $urandom_range(0, 99) < p_req) begin
                pend_v[i] = 1'b1;
                pend_d[i] = req_t'($urandom);
            end
            req_i[i]        = pend_d[i];
            resp_ready_i[i] = ($urandom_range(0, 99) < p_rr);
        end
        req_valid_i      = pend_v;
        mem_req_ready_i  = ($urandom_range(0, 99) < p_rdy);
        mem_resp_valid_i = (q.size() > 0) && ($urandom_range(0, 99) < p_rv);
        mem_resp_i       = resp_t'($urandom);

        g  = -1;
        gv = 0;
        if (lock >= 0) begin
            g  = lock;
            gv = pend_v[g];
        end else begin
            for (int k = 0; k < NumReq; k++) begin
                int c;
                c = (rr + k) % NumReq;
                if (g < 0 && pend_v[c]) begin
                    g  = c;
                    gv = 1;
                end
            end
        end
        pop  = (q.size() > 0) && mem_resp_valid_i && resp_ready_i[q[0]];
        can  = (q.size() < MaxOut) || pop;
        vout = gv && can;
        hs   = vout && mem_req_ready_i;
        exp_rv = '0;
        if (q.size() > 0 && mem_resp_valid_i) exp_rv[q[0]] = 1'b1;

        #1;
        check_val("mem_req_valid", 64'(mem_req_valid_o), 64'(vout));
        if (gv) begin
            exp_rdy    = '0;
            exp_rdy[g] = mem_req_ready_i && can;
            check_val("mem_req_data", 64'(mem_req_o), 64'(pend_d[g]));
            check_val("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        end
        check_val("resp_valid", 64'(resp_valid_o), 64'(exp_rv));
        check_val("mem_resp_ready", 64'(mem_resp_ready_o),
                  64'((q.size() > 0) && resp_ready_i[q[0]]));
        check_val("resp_data", 64'(resp_o), 64'(mem_resp_i));
        check_counters();

        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (hs) begin
            q.push_back(g);
            rr        = (g + 1) % NumReq;
            lock      = -1;
            pend_v[g] = 1'b0;
            gcnt[g]   = gcnt[g] + 16'd1;
        end else if (vout) begin
            lock = g;
        end
    endtask

    task automatic step();
        @(negedge clk);
        step_body();
    endtask

    task automatic run(input int n, input int a, input int b, input int c, input int d);
        p_req = a;
        p_rdy = b;
        p_rv  = c;
        p_rr  = d;
        for (int i = 0; i < n; i++) step();
    endtask

    // Reset pulse with the response side pushing hard: the flushed queue must own nothing.
    task automatic reset_mid();
        int first;
        @(negedge clk);
        rst              = 1'b1;
        mem_resp_valid_i = 1'b1;
        resp_ready_i     = '1;
        mem_req_ready_i  = 1'b0;
        #1;
        check_val("rst_resp_valid", 64'(resp_valid_o), 64'(0));
        check_val("rst_mem_resp_ready", 64'(mem_resp_ready_o), 64'(0));
        check_val("rst_mem_req_valid", 64'(mem_req_valid_o), 64'(|pend_v));
        first = -1;
        for (int i = 0; i < NumReq; i++) if (first < 0 && pend_v[i]) first = i;
        if (first >= 0) check_val("rst_mem_req_data", 64'(mem_req_o), 64'(pend_d[first]));
        model_reset();
        check_counters();
        @(negedge clk);
        rst = 1'b0;
        step_body();
    endtask

    initial begin
        n_cmp            = 0;
        n_mis            = 0;
        pend_v           = '0;
        for (int i = 0; i < NumReq; i++) pend_d[i] = '0;
        req_i            = '0;
        req_valid_i      = '0;
        resp_ready_i     = '0;
        mem_req_ready_i  = 1'b0;
        mem_resp_i       = '0;
        mem_resp_valid_i = 1'b0;
        model_reset();
        rst              = 1'b1;
        #1;
        check_val("reset_mem_req_valid", 64'(mem_req_valid_o), 64'(0));
        check_val("reset_resp_valid", 64'(resp_valid_o), 64'(0));
        check_val("reset_mem_resp_ready", 64'(mem_resp_ready_o), 64'(0));
        check_counters();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run(40, 100, 100, 100, 100);   // saturated: strict 0,1,2,3,0 rotation
        run(200, 40, 25, 60, 70);      // memory back-pressure exercises locking
        run(20, 100, 100, 0, 100);     // no responses: issue stalls at MaxOut
        run(20, 100, 100, 100, 100);   // pop and push in the same cycle
        run(150, 50, 80, 70, 20);      // requester back-pressure holds the head
        run(1000, 35, 70, 60, 70);
        run(6, 100, 60, 0, 100);
        reset_mid();
        run(300, 40, 70, 60, 70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_stream_arbiter.md
# mem_stream_arbiter

Round-robin arbiter that shares one flow-controlled memory request/response stream pair among `NumReq` requesters. It sits upstream of the memory stream adapter: it grants one requester per cycle, records the granted index in an in-order ID queue, and steers each returning response to the requester that issued it. Responses are returned strictly in issue order; the block adds no latency on either path.

## Interface
- `NumReq`, 4, number of requesters (≥2)
- `MaxOutstanding`, 2, ID-queue depth = max issued-but-unanswered requests (≥1)
- `mem_req_t`, logic, request payload type
- `mem_resp_t`, logic, response payload type
- `clk_i`  in  1  clock, single clock domain
- `rst_i`  in  1  asynchronous, active-high reset
- `req_i`  in  NumReq x mem_req_t  requester payloads
- `req_valid_i`  in  NumReq  requester valid
- `req_ready_o`  out  NumReq  requester ready
- `resp_o`  out  mem_resp_t  response payload, broadcast to all requesters
- `resp_valid_o`  out  NumReq  one-hot response valid
- `resp_ready_i`  in  NumReq  requester response ready
- `mem_req_o`  out  mem_req_t  granted payload
- `mem_req_valid_o`  out  1  memory request valid
- `mem_req_ready_i`  in  1  memory request ready
- `mem_resp_i`  in  mem_resp_t  memory response payload
- `mem_resp_valid_i`  in  1  memory response valid
- `mem_resp_ready_o`  out  1  memory response ready
- `grant_cnt_o`  out  NumReq x 16  per-requester grant counters (see Configuration)

## Operation
- State: `rr_ptr` (IdxW = $clog2(NumReq)), `lock_q` + `lock_idx_q`, ID queue (IdxW-wide, depth MaxOutstanding), occupancy `cnt_q` ($clog2(MaxOutstanding+1) bits).
- Arbiter states: FREE (lock_q=0) and LOCKED (lock_q=1).
- FREE: grant = first i with `req_valid_i[i]`, scanning from `rr_ptr` upward, wrapping at NumReq-1 -> 0.
- LOCKED: grant = `lock_idx_q`; other valids are ignored.
- `can_issue` = (cnt_q < MaxOutstanding) | response pop this cycle.
- `mem_req_valid_o` = granted valid & can_issue; `mem_req_o` = `req_i[grant]`; `req_ready_o[grant]` = `mem_req_ready_i` & can_issue; all other readies are 0.
- FREE -> LOCKED when `mem_req_valid_o` & !`mem_req_ready_i`; `lock_idx_q` := grant. The payload source is therefore stable until the handshake.
- Handshake (valid & ready): push grant into ID queue, `rr_ptr` := (grant+1) mod NumReq, lock_q := 0.
- Response: head = ID-queue head. When the queue is non-empty, `resp_valid_o[head]` = `mem_resp_valid_i` and `mem_resp_ready_o` = `resp_ready_i[head]`. Pop on that handshake.
- Empty queue: `resp_valid_o` = 0 and `mem_resp_ready_o` = 0; a response arriving while empty is a protocol error (assertion).
- Simultaneous push and pop: `cnt_q` is unchanged; allowed even when full.
- `resp_o` = `mem_resp_i` unconditionally.

## Timing
- Reset values: `rr_ptr`=0, lock_q=0, cnt_q=0, queue empty, grant counters 0.
- Reset-derived outputs: `mem_req_valid_o`=0 only if no valid is present; `resp_valid_o`=0; `mem_resp_ready_o`=0.
- Request and response paths are purely combinational (0-cycle latency); state updates on `posedge clk_i`.
- Reset asserted mid-transaction flushes the ID queue and lock. In-flight memory responses are then unowned; upstream must be quiesced or reset together with this block.
- Fairness: a continuously valid requester is granted within NumReq handshakes.

## Configuration
- `MEM_ARB_GRANT_CNT_EN` defined:
  - `grant_cnt_o[i]` increments on each request handshake for requester i.
  - 16-bit, wraps at 0xFFFF -> 0; cleared by reset.
- Not defined: `grant_cnt_o` is tied to 0 and no counter flops are built.

## Structure
- `mem_arb_pkg`: arbiter state enum (`ARB_FREE`, `ARB_LOCKED`) and the counter width constant `GrantCntW = 16`.
- ID queue: instance of the existing `stream_fifo`, non-fall-through, DEPTH = MaxOutstanding.
- One new sub-module, `mem_arb_rr`: round-robin priority scan producing grant index and any-valid from `req_valid_i` and `rr_ptr`.

## Test plan
- All 4 valid, `mem_req_ready_i`=1, memory responds next cycle -> grants in order 0,1,2,3,0; each response appears only on the matching `resp_valid_o` bit.
- Req 2 valid, `mem_req_ready_i` held 0 for 3 cycles while req 1 rises -> grant stays 2 (LOCKED), `mem_req_o` stable; req 2 is issued on the ready cycle, req 1 next.
- MaxOutstanding=2, no responses returned -> third request is stalled (`mem_req_valid_o`=0). Returning a response with `resp_ready_i` high in the same cycle -> the third request issues that cycle.
- Response for requester 3 at head with `resp_ready_i[3]`=0 -> `mem_resp_ready_o`=0 and the head is held until ready.
- Reset pulse with 2 requests outstanding -> cnt_q=0, `rr_ptr`=0, lock cleared, `resp_valid_o`=0.
- With `MEM_ARB_GRANT_CNT_EN`, 65537 grants to requester 0 -> `grant_cnt_o[0]`=1; without the macro -> 0.
